// File: rtl/sin_pkg.sv
// Shared definitions for the sine sample receive path.
//   state_t      : capture FSM states (IDLE / CAPTURE / DRAIN)
//   SIN_DW       : default sample width
//   sin_golden() : 15-entry golden sine table, indexed 0..SIN_TABLE_LEN-1
package sin_pkg;

    localparam int unsigned SIN_DW        = 12;
    localparam int unsigned SIN_TABLE_LEN = 15;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    function automatic logic [SIN_DW-1:0] sin_golden(input int unsigned idx);
        logic [SIN_DW-1:0] v;
        case (idx)
            0:       v = 12'hFFF;
            1:       v = 12'hCBE;
            2:       v = 12'hA0D;
            3:       v = 12'h864;
            4:       v = 12'h80B;
            5:       v = 12'h912;
            6:       v = 12'hB4B;
            7:       v = 12'hE55;
            8:       v = 12'h1A8;
            9:       v = 12'h4B2;
            10:      v = 12'h6EB;
            11:      v = 12'h7F2;
            12:      v = 12'h799;
            13:      v = 12'h5F0;
            14:      v = 12'h33F;
            default: v = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/sin_frame_ram.sv
// Frame buffer: DEPTH x DW memory, synchronous write, registered read.
//   clk, rst     : clock, async active-high reset (read register only)
//   we/waddr/wdata : write port
//   re/raddr     : read request; rdata updates on the next edge when re=1
//   rdata        : registered read data, holds its value while re=0
module sin_frame_ram
    import sin_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned DW    = SIN_DW
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DW-1:0]            wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DW-1:0]            rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read register doubles as the output data register, so it must hold
    // during stalls and carry the reset value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/sin_frame_rx.sv
// Frame receiver: captures one vsync/hsync-framed sample burst into a
// buffer, then drains it as a valid/ready stream with a last marker.
//   clkin, rst    : clock, async active-high reset
//   sin_x         : incoming sample
//   vsync, hsync  : framing; active when vsync=0 and hsync=1
//   m_data/m_valid/m_ready/m_last : output stream
//   frame_len     : sample count of the captured frame (0..DEPTH)
//   frame_done    : one-cycle pulse when capture of a frame finishes
//   overflow_err  : sticky, a frame carried more than DEPTH samples
//   drop_cnt      : saturating count of frames started while draining
module sin_frame_rx
    import sin_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned DW    = SIN_DW,
    parameter int unsigned CNTW  = 8
) (
    input  logic                   clkin,
    input  logic                   rst,
    input  logic [DW-1:0]          sin_x,
    input  logic                   vsync,
    input  logic                   hsync,
    output logic [DW-1:0]          m_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic                   m_last,
    output logic [$clog2(DEPTH):0] frame_len,
    output logic                   frame_done,
    output logic                   overflow_err,
    output logic [CNTW-1:0]        drop_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    state_t state, state_nx;

    logic          active, active_q, start, stop;
    logic [PW-1:0] wr_ptr, rd_ptr;

    logic          we, re;
    logic [AW-1:0] waddr, raddr;
    logic          cap_begin, cap_end, fetch, finish, ovf_set, drop;

    assign active = !vsync && hsync;
    assign start  = active && !active_q;
    assign stop   = !active && active_q;

    sin_frame_ram #(
        .DEPTH (DEPTH),
        .DW    (DW)
    ) u_ram (
        .clk   (clkin),
        .rst   (rst),
        .we    (we),
        .waddr (waddr),
        .wdata (sin_x),
        .re    (re),
        .raddr (raddr),
        .rdata (m_data)
    );

    // State register
    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = CAPTURE;
            CAPTURE: if (stop) state_nx = DRAIN;
            DRAIN:   if (m_valid && m_ready && m_last) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Control outputs
    always_comb begin
        we        = 1'b0;
        waddr     = '0;
        re        = 1'b0;
        raddr     = rd_ptr[AW-1:0];
        cap_begin = 1'b0;
        cap_end   = 1'b0;
        fetch     = 1'b0;
        finish    = 1'b0;
        ovf_set   = 1'b0;
        drop      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    cap_begin = 1'b1;
                    we        = 1'b1;
                end
            end
            CAPTURE: begin
                if (active) begin
                    // wr_ptr never exceeds DEPTH, so its top bit alone
                    // flags a full buffer.
                    if (!wr_ptr[AW]) begin
                        we    = 1'b1;
                        waddr = wr_ptr[AW-1:0];
                    end else begin
                        ovf_set = 1'b1;
                    end
                end
                cap_end = stop;
            end
            DRAIN: begin
                // rd_ptr is the next address to fetch; m_valid low in DRAIN
                // only happens on the first cycle after entry.
                if (!m_valid) begin
                    fetch = 1'b1;
                end else if (m_ready) begin
                    if (m_last) finish = 1'b1;
                    else        fetch  = 1'b1;
                end
                re   = fetch;
                drop = start;
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            active_q     <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            m_valid      <= 1'b0;
            m_last       <= 1'b0;
            frame_len    <= '0;
            frame_done   <= 1'b0;
            overflow_err <= 1'b0;
            drop_cnt     <= '0;
        end else begin
            active_q   <= active;
            frame_done <= cap_end;

            if (cap_begin) begin
                wr_ptr <= PW'(1);
            end else if (we) begin
                wr_ptr <= wr_ptr + PW'(1);
            end

            if (ovf_set) begin
                overflow_err <= 1'b1;
            end

            if (cap_end) begin
                frame_len <= wr_ptr;
                rd_ptr    <= '0;
            end else if (fetch) begin
                rd_ptr <= rd_ptr + PW'(1);
            end

            if (fetch) begin
                m_valid <= 1'b1;
                m_last  <= (rd_ptr == frame_len - PW'(1));
            end else if (finish) begin
                m_valid <= 1'b0;
                m_last  <= 1'b0;
            end

            if (drop && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + CNTW'(1);
            end
        end
    end

endmodule

// File: doc/sin_frame_rx.md
Name: sin_frame_rx

Overview:
Receive-side counterpart of the sine sample generator. Captures the 12-bit sample stream framed by vsync/hsync into a frame buffer, then drains each complete frame through a valid/ready stream with a last marker. Sits between the generator output and downstream DSP/checker logic. It reports frame length, overflows and dropped frames.

Parameters:
DEPTH, 16, frame buffer entries; must be a power of 2 and at least 2
DW, 12, sample width
CNTW, 8, width of the saturating drop counter

Ports:
clkin  in  1  single clock; all state updates on the rising edge
rst  in  1  asynchronous, active-high reset
sin_x  in  DW  sample from the generator
vsync  in  1  frame sync; low during an active frame
hsync  in  1  line/active qualifier; high during an active frame
m_data  out  DW  output sample
m_valid  out  1  output sample is valid
m_ready  in  1  downstream accepts m_data when m_valid and m_ready are both high
m_last  out  1  marks the final sample of a frame; qualified by m_valid
frame_len  out  log2(DEPTH)+1  sample count of the frame being drained
frame_done  out  1  one-cycle pulse when a frame finishes capture
overflow_err  out  1  sticky; the frame exceeded DEPTH samples
drop_cnt  out  CNTW  saturating count of frames dropped while draining

Behaviour:
- Generator drives on the falling edge; this block samples on the rising edge. No synchronizers are needed.
- active = (vsync==0 && hsync==1). The combinations (0,0) and (1,1) count as inactive.
- Register active_q. start = active && !active_q; end = !active && active_q.
- Reset (asynchronous): state=IDLE, wr_ptr=0, rd_ptr=0, m_valid=0, m_last=0, m_data=0, frame_len=0, frame_done=0, overflow_err=0, drop_cnt=0, active_q=0.
- State IDLE:
  - On start: write sin_x to mem[0], set wr_ptr=1, go to CAPTURE.
- State CAPTURE:
  - Each active cycle with wr_ptr<DEPTH: mem[wr_ptr]=sin_x, wr_ptr++.
  - An active cycle with wr_ptr==DEPTH discards the sample and sets overflow_err.
  - On end: frame_len=wr_ptr, pulse frame_done for 1 cycle, rd_ptr=0, go to DRAIN.
- State DRAIN:
  - m_valid rises the cycle after entry; m_data=mem[rd_ptr].
  - m_last=(rd_ptr==frame_len-1).
  - On a handshake: rd_ptr++. A handshake with m_last set clears m_valid and goes to IDLE the next cycle.
  - m_data, m_last and m_valid stay stable while m_valid && !m_ready.
- Any start seen in DRAIN drops that entire frame: drop_cnt++ (saturates at all-ones). A frame already in progress when DRAIN exits to IDLE is ignored until its end; capture waits for the next start.
- Single-sample frame: frame_len=1, and m_last is high on the first beat.
- Frame of exactly DEPTH samples: no overflow_err, and m_last is on sample DEPTH-1.
- Reset asserted mid-frame or mid-drain aborts immediately. Outputs return to reset values and buffer contents are don't-care.
- Latency: the first m_valid is 2 cycles after the first inactive cycle (1 cycle to detect end, 1 cycle for the registered read).
- Width: frame_len counts to DEPTH inclusive, hence log2(DEPTH)+1 bits. wr_ptr uses the same width.

Decomposition:
- Package sin_pkg holds:
  - the state enum IDLE/CAPTURE/DRAIN;
  - the DW default;
  - the 15-entry golden sine table, reused by the generator and the bench.
- One natural sub-module: sin_frame_ram, a DEPTH x DW synchronous-write, registered-read memory.
- Framing detection and the FSM stay in the top level.

Test Plan:
- Golden frame: connect the generator, hold m_ready=1.
  - Required: 15 beats 0xFFF,0xCBE,0xA0D,0x864,0x80B,0x912,0xB4B,0xE55,0x1A8,0x4B2,0x6EB,0x7F2,0x799,0x5F0,0x33F.
  - Required: m_last on 0x33F, frame_len=15, frame_done pulses once, overflow_err=0.
- Backpressure: toggle m_ready 1,0,0,1,... on the golden frame.
  - Required: identical 15-value sequence, m_data/m_last stable during stalls, no duplicates.
- Drop: hold m_ready=0 through two more generator frames.
  - Required: drop_cnt=2; after release, only the first frame drains, then capture resumes on the next start.
- Overflow: an active window of 20 cycles with samples 0x000..0x013.
  - Required: overflow_err=1, frame_len=16, drained data 0x000..0x00F with last on 0x00F.
- Short and invalid sync:
  - A 1-cycle active window with sample 0x123 -> a single beat 0x123 with m_last=1.
  - vsync=1,hsync=1 mid-frame -> frame ends at that cycle.
- Reset mid-drain: assert rst after beat 5.
  - Required: m_valid=0 immediately; the next golden frame drains completely and correctly.
